serial_adder: RTL and testbench

- Parametrised bit-serial adder. It reuses a single full-adder cell over WIDTH cycles to form a + b + cin.
- Successor to the combinational full-adder-from-half-adders block: it generalises the operand width and adds a start/busy/done handshake, a carry register and a bit counter.
- Sits as an area-lean arithmetic unit behind a simple control FSM.

---
 rtl/serial_adder_pkg.sv | 25 ++
 rtl/fa_cell.sv | 16 +
 rtl/serial_adder.sv | 155 +++++++++++++++
 tb/tb_serial_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: state encoding, default width and
// the bit-counter width helper.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] RUN_ENC  = 2'd1;
  localparam logic [1:0] DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    RUN  = RUN_ENC,
    DONE = DONE_ENC
  } state_t;

  // Bit-counter width: $clog2(w), but never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned r;
    r = 1;
    if (w > 1) r = unsigned'($clog2(w));
    return r;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder, reused every cycle by serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  // Sum and carry-out of a single bit position.
  always_comb begin
    s  = a ^ b ^ cin;
    co = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell iterated over WIDTH cycles to form
// {cout,sum} = a + b + cin, with a start/busy/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a sub input (a - b) and a signed
// overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic [WIDTH-1:0]   w_sum_sh_nxt;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_carry_load;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_fa_s;
  logic               w_fa_co;
`ifdef SERIAL_ADDER_SUB_EN
  logic               r_cmsb;
  logic               r_ovf;
`endif

  fa_cell u_fa (
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .cin (r_carry),
    .s   (w_fa_s),
    .co  (w_fa_co)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == LAST_BIT) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand conditioning on load and the shifted partial sum.
  always_comb begin
    w_b_load     = b;
    w_carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      w_b_load     = ~b;
      w_carry_load = 1'b1;
    end
`endif
    w_sum_sh_nxt             = r_sum_sh >> 1;
    w_sum_sh_nxt[WIDTH-1]    = w_fa_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Handshake outputs, registered so busy tracks the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (r_state == DONE);
    end
  end

  // Datapath: load operands, shift one bit per RUN cycle, publish in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      r_cmsb   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_load;
            r_carry <= w_carry_load;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_sh_nxt;
          r_carry  <= w_fa_co;
          r_cnt    <= r_cnt + CNT_W'(1);
`ifdef SERIAL_ADDER_SUB_EN
          // Carry entering the MSB, kept for the overflow flag.
          if (r_cnt == LAST_BIT) r_cmsb <= r_carry;
`endif
        end
        DONE: begin
          r_sum  <= r_sum_sh;
          r_cout <= r_carry;
`ifdef SERIAL_ADDER_SUB_EN
          r_ovf  <= r_cmsb ^ r_carry;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_SUB_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 4 and 1. Honours
// SERIAL_ADDER_SUB_EN when defined.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8, ovf8, ovf4, ovf1;
  logic       qovf[$];
`endif

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [1:0] q1[$];

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] prev8;
  logic       have_prev;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8), .ovf(ovf8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0), .ovf(ovf4),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0), .ovf(ovf1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitors: pop the oldest expectation on every done pulse.
  task automatic mon8();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (done8) begin
        if (q8.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL done8_unexpected: got done=1 expected no pulse at %0t", $time);
        end else begin
          e = q8.pop_front();
          chk("result8", 32'({cout8, sum8}), 32'(e));
`ifdef SERIAL_ADDER_SUB_EN
          if (qovf.size() != 0) chk("ovf8", 32'(ovf8), 32'(qovf.pop_front()));
`endif
        end
      end
    end
  endtask

  task automatic mon4();
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (done4) begin
        if (q4.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL done4_unexpected: got done=1 expected no pulse at %0t", $time);
        end else begin
          e = q4.pop_front();
          chk("result4", 32'({cout4, sum4}), 32'(e));
        end
      end
    end
  endtask

  task automatic mon1();
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (done1) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL done1_unexpected: got done=1 expected no pulse at %0t", $time);
        end else begin
          e = q1.pop_front();
          chk("result1", 32'({cout1, sum1}), 32'(e));
        end
      end
    end
  endtask

  // Bounded wait until the 8-bit unit drops busy; returns cycles spent busy.
  task automatic wait_idle8(output int cyc);
    cyc = 0;
    while (busy8 && cyc < 50) begin
      cyc++;
      if (cyc == 5 && have_prev) chk("hold_during_run8", 32'({cout8, sum8}), 32'(prev8));
      @(negedge clk);
    end
    if (cyc >= 50) chk("busy8_timeout", 32'(busy8), 32'(0));
  endtask

  task automatic add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [8:0] exp);
    int cyc;
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    q8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8(cyc);
    chk("busy8_cycles", 32'(cyc), 32'(9));
    prev8 = exp; have_prev = 1'b1;
    @(negedge clk);
  endtask

  task automatic add4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                      input logic [4:0] exp);
    int cyc;
    @(negedge clk);
    a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
    q4.push_back(exp);
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (busy4 && cyc < 50) begin cyc++; @(negedge clk); end
    chk("busy4_cycles", 32'(cyc), 32'(5));
  endtask

  task automatic add1(input logic ta, input logic tb, input logic tc, input logic [1:0] exp);
    int cyc;
    @(negedge clk);
    a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
    q1.push_back(exp);
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (busy1 && cyc < 50) begin cyc++; @(negedge clk); end
    chk("busy1_cycles", 32'(cyc), 32'(2));
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0;
`endif
    prev8 = '0; have_prev = 1'b0;
    fork
      mon8();
      mon4();
      mon1();
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'(0));
    chk("rst_done8", 32'(done8), 32'(0));
    chk("rst_result8", 32'({cout8, sum8}), 32'(0));
    chk("rst_result4", 32'({cout4, sum4}), 32'(0));
    rst = 1'b0;

    // Directed additions.
    add8(8'h0F, 8'h01, 1'b0, 9'h010);
    add8(8'hFF, 8'h01, 1'b0, 9'h100);
    add8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    add8(8'h12, 8'h34, 1'b1, 9'h047);
    add8(8'hA5, 8'h5A, 1'b1, 9'h100);

    // Start during RUN is ignored and not queued.
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h010);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8(cyc);
    prev8 = 9'h010;
    repeat (2) @(negedge clk);
    chk("ignored_start_busy8", 32'(busy8), 32'(0));
    chk("ignored_start_hold8", 32'({cout8, sum8}), 32'(9'h010));
    add8(8'h20, 8'h22, 1'b0, 9'h042);

    // Reset in the fourth RUN cycle aborts without a done pulse.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h077);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(q8.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy8", 32'(busy8), 32'(0));
    chk("abort_done8", 32'(done8), 32'(0));
    chk("abort_result8", 32'({cout8, sum8}), 32'(0));
    repeat (15) @(negedge clk);
    chk("abort_idle8", 32'(busy8), 32'(0));
    prev8 = '0;
    add8(8'h33, 8'h44, 1'b0, 9'h077);

    // Reset and start together: reset wins.
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1; rst = 1'b1;
    @(negedge clk);
    start8 = 1'b0; rst = 1'b0;
    chk("rst_start_busy8", 32'(busy8), 32'(0));
    repeat (12) @(negedge clk);
    prev8 = '0;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction mode.
    sub8 = 1'b1;
    qovf.push_back(1'b0);
    add8(8'h05, 8'h07, 1'b1, 9'h0FE);
    qovf.push_back(1'b1);
    add8(8'h80, 8'h01, 1'b0, 9'h17F);
    sub8 = 1'b0;
`endif

    // Exhaustive sweeps at WIDTH 4 and WIDTH 1.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          add4(4'(ia), 4'(ib), 1'(ic), 5'(ia + ib + ic));
    for (int ia = 0; ia < 2; ia++)
      for (int ib = 0; ib < 2; ib++)
        for (int ic = 0; ic < 2; ic++)
          add1(1'(ia), 1'(ib), 1'(ic), 2'(ia + ib + ic));

    repeat (6) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'(0));
    chk("q4_drained", 32'(q4.size()), 32'(0));
    chk("q1_drained", 32'(q1.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1);
  end

endmodule
